// File: rtl/bsg_nasti_rd_arbiter.sv
// Two-client NASTI read arbiter: round-robin AR grant with per-client outstanding-burst throttling, R routed by ID MSB.
// Optional monitor (handshake trace plus underflow check) enabled by defining BSG_NASTI_RD_ARB_MONITOR_EN.
module bsg_nasti_rd_arbiter #(
  parameter int id_width_p        = 5,
  parameter int addr_width_p      = 32,
  parameter int data_width_p      = 64,
  parameter int max_outstanding_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic [1:0]                c_ar_valid_i,
  output logic [1:0]                c_ar_ready_o,
  input  logic [2*id_width_p-1:0]   c_ar_id_i,
  input  logic [2*addr_width_p-1:0] c_ar_addr_i,
  input  logic [15:0]               c_ar_len_i,

  output logic                      m_ar_valid_o,
  input  logic                      m_ar_ready_i,
  output logic [id_width_p:0]       m_ar_id_o,
  output logic [addr_width_p-1:0]   m_ar_addr_o,
  output logic [7:0]                m_ar_len_o,

  input  logic                      m_r_valid_i,
  output logic                      m_r_ready_o,
  input  logic [id_width_p:0]       m_r_id_i,
  input  logic [data_width_p-1:0]   m_r_data_i,
  input  logic [1:0]                m_r_resp_i,
  input  logic                      m_r_last_i,

  output logic [1:0]                c_r_valid_o,
  input  logic [1:0]                c_r_ready_i,
  output logic [id_width_p-1:0]     c_r_id_o,
  output logic [data_width_p-1:0]   c_r_data_o,
  output logic [1:0]                c_r_resp_o,
  output logic                      c_r_last_o
);

  localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);
  localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(max_outstanding_p);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                  state_r, state_n;
  logic                    grant_idx_r, grant_idx_n;
  logic                    rr_ptr_r, rr_ptr_n;
  logic [cnt_width_lp-1:0] cnt_r [2];
  logic [1:0]              eligible;
  logic                    ar_hs;
  logic                    r_sel;
  logic                    r_last_hs;

  // Simultaneous issue and retire for one client leave its count untouched; saturates at both ends.
  function automatic logic [cnt_width_lp-1:0] cnt_update(
    input logic [cnt_width_lp-1:0] cnt,
    input logic                    inc,
    input logic                    dec
  );
    logic [cnt_width_lp-1:0] res;
    res = cnt;
    if (inc && !dec && (cnt < cnt_max_lp))
      res = cnt + 1'b1;
    else if (dec && !inc && (cnt != '0))
      res = cnt - 1'b1;
    return res;
  endfunction

  assign eligible[0] = c_ar_valid_i[0] & (cnt_r[0] < cnt_max_lp);
  assign eligible[1] = c_ar_valid_i[1] & (cnt_r[1] < cnt_max_lp);

  assign ar_hs     = (state_r == GRANT) & m_ar_ready_i;
  assign r_sel     = m_r_id_i[id_width_p];
  assign r_last_hs = m_r_valid_i & m_r_ready_o & m_r_last_i;

  always_comb begin
    state_n     = state_r;
    grant_idx_n = grant_idx_r;
    rr_ptr_n    = rr_ptr_r;
    unique case (state_r)
      IDLE: begin
        if (|eligible) begin
          grant_idx_n = eligible[rr_ptr_r] ? rr_ptr_r : ~rr_ptr_r;
          state_n     = GRANT;
        end
      end
      GRANT: begin
        // Grant is held until the master accepts, keeping the AR payload stable.
        if (m_ar_ready_i) begin
          rr_ptr_n = ~grant_idx_r;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r     <= IDLE;
      grant_idx_r <= 1'b0;
      rr_ptr_r    <= 1'b0;
      cnt_r[0]    <= '0;
      cnt_r[1]    <= '0;
    end else begin
      state_r     <= state_n;
      grant_idx_r <= grant_idx_n;
      rr_ptr_r    <= rr_ptr_n;
      cnt_r[0]    <= cnt_update(cnt_r[0], ar_hs & ~grant_idx_r, r_last_hs & ~r_sel);
      cnt_r[1]    <= cnt_update(cnt_r[1], ar_hs &  grant_idx_r, r_last_hs &  r_sel);
    end
  end

  // AR payload comes straight from the granted client; that client holds it until ready.
  always_comb begin
    m_ar_valid_o = (state_r == GRANT);
    c_ar_ready_o = '0;
    if (ar_hs)
      c_ar_ready_o = grant_idx_r ? 2'b10 : 2'b01;
    if (grant_idx_r) begin
      m_ar_id_o   = {1'b1, c_ar_id_i[2*id_width_p-1:id_width_p]};
      m_ar_addr_o = c_ar_addr_i[2*addr_width_p-1:addr_width_p];
      m_ar_len_o  = c_ar_len_i[15:8];
    end else begin
      m_ar_id_o   = {1'b0, c_ar_id_i[id_width_p-1:0]};
      m_ar_addr_o = c_ar_addr_i[addr_width_p-1:0];
      m_ar_len_o  = c_ar_len_i[7:0];
    end
  end

  // R path is pure steering: no storage, so beats cannot be lost or reordered.
  always_comb begin
    c_r_valid_o = '0;
    if (m_r_valid_i)
      c_r_valid_o = r_sel ? 2'b10 : 2'b01;
  end

  assign m_r_ready_o = c_r_ready_i[r_sel];
  assign c_r_id_o    = m_r_id_i[id_width_p-1:0];
  assign c_r_data_o  = m_r_data_i;
  assign c_r_resp_o  = m_r_resp_i;
  assign c_r_last_o  = m_r_last_i;

`ifdef BSG_NASTI_RD_ARB_MONITOR_EN
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      if (ar_hs)
        $display("ARB_AR c%0d id:%b addr:%b len:%b",
                 grant_idx_r, m_ar_id_o, m_ar_addr_o, m_ar_len_o);
      if (r_last_hs) begin
        $display("ARB_RLAST c%0d cnt:%d", r_sel, cnt_r[r_sel]);
        assert (cnt_r[r_sel] != '0)
          else $error("bsg_nasti_rd_arbiter: R-last for client %0d with no outstanding burst", r_sel);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_bsg_nasti_rd_arbiter.sv
// Bench for bsg_nasti_rd_arbiter: directed scenarios then random traffic, checked against a transaction-level model.
module tb_bsg_nasti_rd_arbiter;

  localparam int IW = 5;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    c_ar_valid, c_ar_ready;
  logic [2*IW-1:0] c_ar_id;
  logic [2*AW-1:0] c_ar_addr;
  logic [15:0]   c_ar_len;
  logic          m_ar_valid, m_ar_ready;
  logic [IW:0]   m_ar_id;
  logic [AW-1:0] m_ar_addr;
  logic [7:0]    m_ar_len;
  logic          m_r_valid, m_r_ready;
  logic [IW:0]   m_r_id;
  logic [DW-1:0] m_r_data;
  logic [1:0]    m_r_resp;
  logic          m_r_last;
  logic [1:0]    c_r_valid, c_r_ready;
  logic [IW-1:0] c_r_id;
  logic [DW-1:0] c_r_data;
  logic [1:0]    c_r_resp;
  logic          c_r_last;

  always #5 clk = ~clk;

  bsg_nasti_rd_arbiter #(
    .id_width_p(IW), .addr_width_p(AW), .data_width_p(DW), .max_outstanding_p(MAXO)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .c_ar_valid_i(c_ar_valid), .c_ar_ready_o(c_ar_ready), .c_ar_id_i(c_ar_id),
    .c_ar_addr_i(c_ar_addr), .c_ar_len_i(c_ar_len),
    .m_ar_valid_o(m_ar_valid), .m_ar_ready_i(m_ar_ready), .m_ar_id_o(m_ar_id),
    .m_ar_addr_o(m_ar_addr), .m_ar_len_o(m_ar_len),
    .m_r_valid_i(m_r_valid), .m_r_ready_o(m_r_ready), .m_r_id_i(m_r_id),
    .m_r_data_i(m_r_data), .m_r_resp_i(m_r_resp), .m_r_last_i(m_r_last),
    .c_r_valid_o(c_r_valid), .c_r_ready_i(c_r_ready), .c_r_id_o(c_r_id),
    .c_r_data_o(c_r_data), .c_r_resp_o(c_r_resp), .c_r_last_o(c_r_last)
  );

  int n_checks = 0;
  int n_err = 0;

  // Reference model: outstanding bursts per client, pending grant (-1 none), next preferred client.
  int outst[2];
  int g;
  int rr;
  logic [IW:0]   g_id;
  logic [AW-1:0] g_addr;
  logic [7:0]    g_len;
  bit [1:0] ar_hs;
  bit       r_hs;
  int ar_log[$];
  logic [DW-1:0] rdata_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic check_outputs();
    logic [1:0] exp_car, exp_crv;
    int s;
    chk("m_ar_valid", m_ar_valid, 64'(g >= 0));
    exp_car = '0;
    if (g >= 0) begin
      chk("m_ar_id", m_ar_id, g_id);
      chk("m_ar_addr", m_ar_addr, g_addr);
      chk("m_ar_len", m_ar_len, g_len);
      if (m_ar_ready) exp_car[g] = 1'b1;
    end
    chk("c_ar_ready", c_ar_ready, exp_car);
    s = int'(m_r_id[IW]);
    exp_crv = '0;
    if (m_r_valid) exp_crv[s] = 1'b1;
    chk("c_r_valid", c_r_valid, exp_crv);
    chk("m_r_ready", m_r_ready, c_r_ready[s]);
    chk("c_r_id", c_r_id, m_r_id[IW-1:0]);
    if (m_r_valid) begin
      chk("c_r_data", c_r_data, m_r_data);
      chk("c_r_resp", c_r_resp, m_r_resp);
      chk("c_r_last", c_r_last, m_r_last);
    end
  endtask

  // Applies the transactions that the coming rising edge will complete.
  task automatic model_update();
    int s;
    bit inc, dec;
    bit [1:0] elig;
    ar_hs = '0;
    r_hs  = 1'b0;
    if (!rst_n) begin
      outst[0] = 0; outst[1] = 0; g = -1; rr = 0;
      return;
    end
    s    = int'(m_r_id[IW]);
    r_hs = m_r_valid && c_r_ready[s];
    if (r_hs && s == 1) rdata_log.push_back(c_r_data);
    dec = r_hs && m_r_last;
    inc = 1'b0;
    if (g >= 0) begin
      if (m_ar_ready) begin
        ar_hs[g] = 1'b1;
        ar_log.push_back(int'(m_ar_id[IW]));
        inc = (dec && s == g) ? 1'b0 : 1'b1;
        if (inc) outst[g]++;
        rr = 1 - g;
        g  = -1;
      end
    end else begin
      for (int i = 0; i < 2; i++) elig[i] = c_ar_valid[i] && (outst[i] < MAXO);
      if (elig != 0) begin
        g      = elig[rr] ? rr : 1 - rr;
        g_id   = {1'(g), c_ar_id[g*IW +: IW]};
        g_addr = c_ar_addr[g*AW +: AW];
        g_len  = c_ar_len[g*8 +: 8];
      end
    end
    if (dec && !ar_hs[s] && outst[s] > 0) outst[s]--;
  endtask

  task automatic tick();
    @(negedge clk); #1;
    check_outputs();
    model_update();
    @(posedge clk); #1;
  endtask

  task automatic drop_hs();
    for (int i = 0; i < 2; i++) if (ar_hs[i]) c_ar_valid[i] = 1'b0;
    if (r_hs) m_r_valid = 1'b0;
  endtask

  task automatic new_req(input int i);
    c_ar_id[i*IW +: IW]   = IW'($urandom);
    c_ar_addr[i*AW +: AW] = $urandom;
    c_ar_len[i*8 +: 8]    = 8'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; c_ar_valid = '0; m_r_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    ar_log.delete(); rdata_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, zeros;
    g = -1; rr = 0; outst[0] = 0; outst[1] = 0;
    rst_n = 1'b0; c_ar_valid = '0; c_ar_id = '0; c_ar_addr = '0; c_ar_len = '0;
    m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_id = '0; m_r_data = '0; m_r_resp = '0;
    m_r_last = 1'b0; c_r_ready = '0;

    // Reset state with all inputs quiet.
    do_reset();
    chk("rst_m_ar_valid", m_ar_valid, 0);
    chk("rst_c_ar_ready", c_ar_ready, 0);
    chk("rst_c_r_valid", c_r_valid, 0);

    // Single c0 request: grant one edge after valid, id {0,3}.
    c_ar_valid = 2'b01; c_ar_id[4:0] = 5'd3; c_ar_addr[31:0] = 32'h1000; c_ar_len[7:0] = 8'd3;
    m_ar_ready = 1'b1;
    tick();
    chk("t1_valid", m_ar_valid, 1);
    chk("t1_id", m_ar_id, 6'b000011);
    chk("t1_addr", m_ar_addr, 32'h1000);
    tick(); drop_hs();
    chk("t1_hs", ar_log.size(), 1);

    // Both clients continuously requesting alternate starting with c0.
    do_reset();
    c_ar_valid = 2'b11; new_req(0); new_req(1); m_ar_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      for (int j = 0; j < 2; j++) if (ar_hs[j]) new_req(j);
    end
    chk("t2_count", ar_log.size(), 4);
    if (ar_log.size() >= 4) begin
      chk("t2_g0", ar_log[0], 0); chk("t2_g1", ar_log[1], 1);
      chk("t2_g2", ar_log[2], 0); chk("t2_g3", ar_log[3], 1);
    end

    // Outstanding limit blocks c0; c1 still served; one c0 R-last reopens c0.
    do_reset();
    c_ar_valid = 2'b01; new_req(0);
    for (int i = 0; i < 14; i++) begin tick(); if (ar_hs[0]) new_req(0); end
    chk("t3_blocked", ar_log.size(), MAXO);
    c_ar_valid[1] = 1'b1; new_req(1);
    for (int i = 0; i < 4; i++) begin tick(); if (ar_hs[1]) c_ar_valid[1] = 1'b0; end
    chk("t3_c1_count", ar_log.size(), MAXO + 1);
    if (ar_log.size() > MAXO) chk("t3_c1_idx", ar_log[MAXO], 1);
    m_r_valid = 1'b1; m_r_id = 6'b000111; m_r_data = 64'h55; m_r_last = 1'b1; c_r_ready = 2'b01;
    tick(); drop_hs();
    for (int i = 0; i < 3; i++) begin tick(); if (ar_hs[0]) new_req(0); end
    zeros = 0;
    foreach (ar_log[i]) if (ar_log[i] == 0) zeros++;
    chk("t3_reopen", zeros, MAXO + 1);

    // Master stalls for 5 cycles; grant and payload must hold.
    do_reset();
    m_ar_ready = 1'b0; c_ar_valid = 2'b10; new_req(1);
    k = 0;
    while (!m_ar_valid && k < 4) begin tick(); k++; end
    chk("t4_grant", m_ar_valid, 1);
    c_ar_valid[0] = 1'b1; new_req(0);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_stall_id", m_ar_id[IW], 1);
    m_ar_ready = 1'b1;
    tick(); drop_hs();
    tick(); tick(); drop_hs();

    // Four R beats to c1 with its ready toggling.
    m_r_id = 6'b100101; m_r_last = 1'b0; c_r_ready = 2'b00;
    for (int b = 0; b < 4; b++) begin
      m_r_valid = 1'b1; m_r_data = 64'hA0 + 64'(b); m_r_resp = 2'(b); m_r_last = (b == 3);
      k = 0;
      do begin
        c_r_ready[1] = ~c_r_ready[1];
        if (b == 0 && k == 0) chk("t5_c_r_id", c_r_id, 5);
        tick(); k++;
      end while (!r_hs && k < 6);
      chk("t5_beat_hs", r_hs, 1);
      drop_hs();
    end
    chk("t5_beats", rdata_log.size(), 4);
    if (rdata_log.size() == 4)
      for (int b = 0; b < 4; b++) chk("t5_data", rdata_log[b], 64'hA0 + 64'(b));

    // Same-cycle c1 AR and c1 R-last, then reset mid-burst.
    do_reset();
    c_ar_valid = 2'b10; new_req(1); m_ar_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin tick(); drop_hs(); end
    c_ar_valid = 2'b10; new_req(1); m_ar_ready = 1'b0;
    k = 0;
    while (!m_ar_valid && k < 4) begin tick(); k++; end
    m_ar_ready = 1'b1; m_r_valid = 1'b1; m_r_id = 6'b100001; m_r_last = 1'b1; c_r_ready = 2'b10;
    tick(); drop_hs();
    chk("t6_same_hs", ar_hs[1] && r_hs, 1);
    c_ar_valid = 2'b10; new_req(1); ar_log.delete();
    for (int i = 0; i < 10; i++) begin tick(); if (ar_hs[1]) new_req(1); end
    chk("t6_remaining", ar_log.size(), MAXO - 1);
    m_r_valid = 1'b1; m_r_last = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", m_ar_valid, 0);
    chk("t6_rst_ready", c_ar_ready, 0);
    m_r_valid = 1'b0; c_ar_valid = '0;
    tick();
    chk("t6_rst_rvalid", c_r_valid, 0);
    rst_n = 1'b1;

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++)
        if (ar_hs[i] || !c_ar_valid[i]) begin
          c_ar_valid[i] = 1'($urandom_range(0, 1));
          new_req(i);
        end
      m_ar_ready = ($urandom_range(0, 3) != 0);
      if (r_hs || !m_r_valid) begin
        k = $urandom_range(0, 1);
        m_r_valid = 1'b0;
        if (outst[k] > 0 && $urandom_range(0, 1) == 1) begin
          m_r_valid = 1'b1;
          m_r_id    = {1'(k), 5'($urandom)};
          m_r_data  = {$urandom, $urandom};
          m_r_resp  = 2'($urandom);
          m_r_last  = ($urandom_range(0, 2) == 0);
        end
      end
      c_r_ready = 2'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
